// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA output path:
//   - default 640x480@60 timing (pixels / lines) and the derived totals
//   - sync polarity (both syncs are active-low for this mode)
//   - sync_t: the {hs, vs, de} bundle carried through the latency delay line
//   - SYNC_IDLE: value of the delay line while in reset (syncs inactive,
//     display disabled)
//   - expand332: 3-3-2 colour to 8-8-8 by bit replication
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing, in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // clk cycles per pixel and pixel ticks of upstream latency
    localparam int PIX_DIV_DEF  = 2;
    localparam int PIPE_LAT_DEF = 1;

    // Width of the pixel/line counters
    localparam int CNT_W = 11;

    // Level driven on hSync/vSync while the sync pulse is active
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, de: 1'b0};

    // Bit replication keeps full white at FF and black at 00 on every channel.
    function automatic logic [23:0] expand332(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// -----------------------------------------------------------------------------
// vga_sync_delay
// Enable-gated shift register of DEPTH stages for the {hs, vs, de} bundle.
// Every stage resets to SYNC_IDLE.
// Ports:
//   clk     system clock
//   resetN  asynchronous, active-low reset
//   en      shift enable (one pixel tick)
//   d       raw bundle entering the line
//   q       last stage (what the display sees)
//   q_next  value that q takes on the next enabled shift; lets a register
//           loaded on the same tick line up with q
// -----------------------------------------------------------------------------
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  resetN,
    input  logic  en,
    input  sync_t d,
    output sync_t q,
    output sync_t q_next
);

    sync_t stages [DEPTH];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= SYNC_IDLE;
            end
        end else if (en) begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_single
            assign q_next = d;
        end else begin : g_multi
            assign q_next = stages[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_output_controller.sv
// -----------------------------------------------------------------------------
// vga_output_controller
// Free-running raster timing generator and VGA output stage.
// A clk divider produces a one-clk pixel tick; horizontal and vertical
// counters advance on that tick and are published as pixelX/pixelY for the
// object drawers. The drawers and priority mux return a 3-3-2 colour PIPE_LAT
// ticks later, so the raw syncs and display enable are delayed by PIPE_LAT
// ticks to land on the same pixel as the registered 8-8-8 colour.
// Ports:
//   clk           system clock
//   resetN        asynchronous, active-low reset
//   RGBIn         {R[2:0],G[2:0],B[1:0]} from the object mux
//   pixTick       one-clk pixel enable
//   pixelX/Y      current horizontal / vertical count
//   drawEn        current coordinate is inside the visible area
//   startOfFrame  one-clk pulse after the tick that wraps to (0,0)
//   hSync/vSync   active-low syncs, latency aligned
//   blankN        1 while a visible pixel is on the output
//   red/green/blue expanded colour, zero outside the visible area
// -----------------------------------------------------------------------------
module vga_output_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_DIV  = PIX_DIV_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [7:0]       RGBIn,
    output logic             pixTick,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             drawEn,
    output logic             startOfFrame,
    output logic             hSync,
    output logic             vSync,
    output logic             blankN,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A divide-by-1 still needs a one-bit register that simply stays at 0.
    localparam int                DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    // -------------------------------------------------------------------------
    // Pixel divider
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    // Gated by resetN so the tick is low for the whole reset, even when
    // PIX_DIV is 1 and the divider compare is always true.
    assign tick    = resetN && (div_q == DIV_LAST);
    assign pixTick = tick;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Raster counters and frame pulse
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;
    logic             sof_q;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_q   <= '0;
            v_q   <= '0;
            sof_q <= 1'b0;
        end else begin
            // Only the tick that leaves the very last pixel of the frame
            // raises the pulse; the reset itself never does.
            sof_q <= tick && h_wrap && v_wrap;
            if (tick) begin
                if (h_wrap) begin
                    h_q <= '0;
                    v_q <= v_wrap ? '0 : v_q + CNT_W'(1);
                end else begin
                    h_q <= h_q + CNT_W'(1);
                end
            end
        end
    end

    assign pixelX       = h_q;
    assign pixelY       = v_q;
    assign startOfFrame = sof_q;
    assign drawEn       = (h_q < H_VIS) && (v_q < V_VIS);

    // -------------------------------------------------------------------------
    // Raw syncs for the coordinate currently issued
    // -------------------------------------------------------------------------
    logic  in_hs;
    logic  in_vs;
    sync_t raw;

    assign in_hs  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign in_vs  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign raw.hs = in_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign raw.vs = in_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign raw.de = drawEn;

    // -------------------------------------------------------------------------
    // Latency alignment
    // -------------------------------------------------------------------------
    sync_t dly_q;
    sync_t dly_next;

    vga_sync_delay #(
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .en     (tick),
        .d      (raw),
        .q      (dly_q),
        .q_next (dly_next)
    );

    assign hSync  = dly_q.hs;
    assign vSync  = dly_q.vs;
    assign blankN = dly_q.de;

    // -------------------------------------------------------------------------
    // Colour register
    // Loaded on the same tick that moves dly_next into dly_q, so the colour
    // and blankN always describe the same pixel.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (tick) begin
            if (dly_next.de) begin
                {red, green, blue} <= expand332(RGBIn);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: doc/vga_output_controller.md
Name: vga_output_controller

Overview:
Raster timing generator and VGA output stage for the game display. Generates 640x480@60 pixel coordinates for all object drawers upstream and the final priority mux. Consumes the mux's registered 8-bit RGB (3-3-2). Drives hSync/vSync/blankN and 8-8-8 RGB, with the syncs delayed to match the upstream pipeline latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate); legal range >=1
PIPE_LAT, 1, pixel ticks from coordinate issue to matching RGBIn; legal range >=1

Ports:
clk  in  1  system clock
resetN  in  1  reset; asynchronous, active-low
RGBIn  in  8  pixel colour from object mux, {R[2:0],G[2:0],B[1:0]}
pixTick  out  1  one-clk pixel enable
pixelX  out  11  current horizontal count (0..H_TOTAL-1)
pixelY  out  11  current vertical count (0..V_TOTAL-1)
drawEn  out  1  pixelX<H_ACTIVE && pixelY<V_ACTIVE
startOfFrame  out  1  one-clk pulse on wrap to (0,0)
hSync  out  1  horizontal sync, active-low, latency-aligned
vSync  out  1  vertical sync, active-low, latency-aligned
blankN  out  1  1 = visible pixel on output, latency-aligned
red  out  8  expanded red
green  out  8  expanded green
blue  out  8  expanded blue

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider 0..PIX_DIV-1. pixTick=1 on the clk where divider==PIX_DIV-1. With PIX_DIV=1, pixTick is constantly 1.
- Coordinates advance only on pixTick:
  - hCount wraps H_TOTAL-1 -> 0.
  - On that wrap, vCount increments and wraps V_TOTAL-1 -> 0.
  - pixelX/pixelY are the registered counters themselves.
- startOfFrame=1 for exactly one clk: the clk after the tick that moves (H_TOTAL-1,V_TOTAL-1) -> (0,0).
- Raw syncs:
  - hs_raw=0 while hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_raw=0 while vCount in [V_ACTIVE+V_FP, +V_SYNC-1], i.e. 490..491.
  - de_raw=drawEn.
- Delay line: PIPE_LAT stages of {hs,vs,de}, shifted on pixTick only. Outputs hSync/vSync/blankN are the last stage.
- RGB output:
  - Registered on pixTick.
  - If the delayed de=1: red={R,R,R[2:1]}, green={G,G,G[2:1]}, blue={B,B,B,B}.
  - Otherwise all three are 0.
  - Held between ticks.
- Upstream contract: RGBIn must be stable for the coordinate issued PIPE_LAT ticks earlier. Total upstream clk latency must be <= PIPE_LAT*PIX_DIV-1.
- Reset (asynchronous, any time incl. mid-frame):
  - Divider, counters, pixelX, pixelY = 0; drawEn=1 (combinational from counters).
  - startOfFrame=0, pixTick=0.
  - Delay line filled with {1,1,0}; hSync=1, vSync=1, blankN=0; red/green/blue=0.
  - After release, the frame restarts at (0,0). No startOfFrame is issued for the reset itself.
- No other inputs; the block is free-running.

Decomposition:
- vga_pkg holds:
  - the default timing localparams and derived H_TOTAL/V_TOTAL;
  - the sync polarity constant;
  - a function expand332 returning the 24-bit colour.
- Sub-module vga_sync_delay: parameterized-depth, enable-gated shift register for {hs,vs,de} with reset value {1,1,0}.

Test Plan:
1. Release reset, PIX_DIV=2 -> pixTick every 2nd clk. pixelX 0,1,2…; hSync first falls on the tick after pixelX=656 and rises after pixelX=752. pixelX 799->0 with pixelY 0->1.
2. Run to line 490 -> vSync low for exactly 1600 pixTicks (lines 490-491), high otherwise.
3. RGBIn mapping, active area:
   - 8'hE0 -> FF/00/00
   - 8'h1C -> 00/FF/00
   - 8'h03 -> 00/00/FF
   - 8'hA9 -> B6/49/55
4. Bench mux model drives RGBIn=pixelX[7:0] one clk late -> whenever blankN=1, red/green/blue match expand332 of the X from PIPE_LAT ticks earlier. blankN rises exactly 1 tick after drawEn rises.
5. RGBIn=8'hFF held constantly -> outputs 0 and blankN=0 for delayed X 640..799 and Y 480..524.
6. startOfFrame:
   - exactly one 1-clk pulse per 840000 clks, the first 420000 pixTicks after release;
   - assert resetN=0 at (300,200) -> all outputs reach reset values without waiting for clk;
   - after release, next pulse again after 420000 pixTicks.
